// File: rtl/dmem_access_unit_if.sv
// Handshaked data-memory port: request channel (addr/wmask/wdata) plus read-response channel.
// The unit is the master; the memory model or DMEM wrapper is the slave.
interface dmem_access_unit_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    modport master (
        output mem_req_valid,
        output mem_addr,
        output mem_wmask,
        output mem_wdata,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_addr,
        input  mem_wmask,
        input  mem_wdata,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data
    );
endinterface

// File: rtl/dmem_access_unit.sv
// M-stage data-memory responder: issues loads/stores to DMEM, formats load data
// by offset/width/sign, and stalls the pipeline until the access completes.
module dmem_access_unit #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [3:0]         req_wmask,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [2:0]         req_funct3,
    output logic               stall,
    output logic               ld_valid,
    output logic [31:0]        ld_data,
    output logic               err,
    dmem_access_unit_if.master dmem
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   addr_q;
    logic [3:0]        wmask_q;
    logic [XLEN-1:0]   wdata_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic              is_load_q;
    logic              mreq_q;

    logic              misaligned_c;
    logic              done_load_c;
    logic              done_err_c;
    logic [7:0]        byte_c;
    logic [15:0]       half_c;
    logic [XLEN-1:0]   fmt_c;

    assign dmem.mem_req_valid = mreq_q;
    assign dmem.mem_addr      = addr_q;
    assign dmem.mem_wmask     = wmask_q;
    assign dmem.mem_wdata     = wdata_q;

    // Combinational stall so the pipeline freezes in the same cycle the request is accepted.
    assign stall = rst_n & (((state_q == IDLE) & req_valid) |
                            (state_q == ISSUE) | (state_q == WAIT_RSP));

    // Only halfword and word loads have alignment constraints; stores pass through.
    always_comb begin
        misaligned_c = 1'b0;
        if (req_wmask == 4'b0000) begin
            if ((req_funct3 == F3_LH) || (req_funct3 == F3_LHU)) begin
                misaligned_c = req_addr[0];
            end else if (req_funct3 == F3_LW) begin
                misaligned_c = (req_addr[1:0] != 2'b00);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        done_load_c = 1'b0;
        done_err_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned_c) begin
                        state_d    = DONE;
                        done_err_c = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (dmem.mem_req_ready) begin
                    state_d = is_load_q ? WAIT_RSP : DONE;
                end
            end
            WAIT_RSP: begin
                if (dmem.mem_rsp_valid) begin
                    state_d     = DONE;
                    done_load_c = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = DONE;
                    done_err_c = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Lane extraction and extension of the returned word.
    always_comb begin
        byte_c = dmem.mem_rsp_data[7:0];
        case (off_q)
            2'd1:    byte_c = dmem.mem_rsp_data[15:8];
            2'd2:    byte_c = dmem.mem_rsp_data[23:16];
            2'd3:    byte_c = dmem.mem_rsp_data[31:24];
            default: byte_c = dmem.mem_rsp_data[7:0];
        endcase
        half_c = off_q[1] ? dmem.mem_rsp_data[31:16] : dmem.mem_rsp_data[15:0];
        case (funct3_q)
            F3_LB:   fmt_c = {{24{byte_c[7]}}, byte_c};
            F3_LBU:  fmt_c = {24'h000000, byte_c};
            F3_LH:   fmt_c = {{16{half_c[15]}}, half_c};
            F3_LHU:  fmt_c = {16'h0000, half_c};
            default: fmt_c = dmem.mem_rsp_data;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wmask_q   <= '0;
            wdata_q   <= '0;
            funct3_q  <= '0;
            off_q     <= '0;
            is_load_q <= 1'b0;
            mreq_q    <= 1'b0;
            ld_valid  <= 1'b0;
            err       <= 1'b0;
            ld_data   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == WAIT_RSP) ? cnt_q + CNT_W'(1) : '0;
            if ((state_q == IDLE) && req_valid) begin
                addr_q    <= {req_addr[31:2], 2'b00};
                wmask_q   <= req_wmask;
                wdata_q   <= req_wdata;
                funct3_q  <= req_funct3;
                off_q     <= req_addr[1:0];
                is_load_q <= (req_wmask == 4'b0000);
            end
            mreq_q   <= (state_d == ISSUE);
            ld_valid <= done_load_c;
            err      <= done_err_c;
            if (done_load_c) begin
                ld_data <= fmt_c;
            end else if (done_err_c) begin
                ld_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomized bench for dmem_access_unit: a transaction-level timeline model predicts
// stall/request/result behaviour cycle by cycle; the bench plays the DMEM side.
module tb_dmem_access_unit;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [3:0]  req_wmask;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        err;

    dmem_access_unit_if dmem_if ();

    dmem_access_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_wmask  (req_wmask),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .stall      (stall),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .err        (err),
        .dmem       (dmem_if)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ld   = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int o, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * o)) & 32'h0000_00FF;
        h = (w >> (16 * (o / 2))) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic bit model_misaligned(input logic [3:0] wm, input logic [2:0] f3, input int o);
        if (wm != 4'b0000) return 1'b0;
        if ((f3 == 3'd1) || (f3 == 3'd5)) return (o % 2) != 0;
        if (f3 == 3'd2) return o != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] flags(input bit s, input bit m, input bit l, input bit e);
        return {28'h0, s, m, l, e};
    endfunction

    // One complete access starting in IDLE; r = ready-low cycles, w = wait cycles before response
    // (w >= TO means the memory never answers).
    task automatic run_txn(input string name, input logic [3:0] wm, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [2:0] f3, input int r,
                           input int w, input logic [31:0] word);
        int  o;
        bit  load;
        bit  mis;
        bit  tmo;
        int  ws;
        int  done;
        bit  es;
        bit  em;
        bit  el;
        bit  ee;
        o    = int'(addr[1:0]);
        load = (wm == 4'b0000);
        mis  = model_misaligned(wm, f3, o);
        tmo  = load && !mis && (w >= int'(TO));
        ws   = 2 + r;
        if (mis)       done = 1;
        else if (!load) done = 2 + r;
        else if (tmo)  done = ws + int'(TO);
        else           done = ws + w + 1;

        for (int k = 0; k <= done; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_valid  = 1'b1;
                req_wmask  = wm;
                req_addr   = addr;
                req_wdata  = wd;
                req_funct3 = f3;
            end else begin
                req_valid  = 1'($urandom % 2);
                req_wmask  = 4'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
                req_funct3 = 3'($urandom);
            end
            if (!mis && (k >= 1) && (k <= 1 + r)) dmem_if.mem_req_ready = (k == 1 + r);
            else                                  dmem_if.mem_req_ready = 1'($urandom % 2);
            if (load && !mis && (k >= ws) && (k < done)) begin
                dmem_if.mem_rsp_valid = !tmo && (k == ws + w);
                dmem_if.mem_rsp_data  = dmem_if.mem_rsp_valid ? word : $urandom;
            end else begin
                dmem_if.mem_rsp_valid = 1'($urandom % 2);
                dmem_if.mem_rsp_data  = $urandom;
            end
            #1;
            es = (k < done);
            em = !mis && (k >= 1) && (k <= 1 + r);
            el = (k == done) && load && !mis && !tmo;
            ee = (k == done) && (mis || tmo);
            if (k == done) begin
                if (mis || tmo) exp_ld = 32'h0;
                else if (load)  exp_ld = model_load(f3, o, word);
            end
            check_eq($sformatf("%s flags k=%0d", name, k),
                     flags(stall, dmem_if.mem_req_valid, ld_valid, err), flags(es, em, el, ee));
            check_eq($sformatf("%s ld_data k=%0d", name, k), ld_data, exp_ld);
            if (em) begin
                check_eq($sformatf("%s mem_addr k=%0d", name, k), dmem_if.mem_addr, {addr[31:2], 2'b00});
                check_eq($sformatf("%s mem_wmask k=%0d", name, k), 32'(dmem_if.mem_wmask), 32'(wm));
                check_eq($sformatf("%s mem_wdata k=%0d", name, k), dmem_if.mem_wdata, wd);
            end
        end
    endtask

    task automatic idle_cycles(input string name, input int n, input bit force_rsp);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            req_valid             = 1'b0;
            dmem_if.mem_req_ready = 1'($urandom % 2);
            dmem_if.mem_rsp_valid = force_rsp ? 1'b1 : 1'($urandom % 2);
            dmem_if.mem_rsp_data  = $urandom;
            #1;
            check_eq($sformatf("%s idle flags k=%0d", name, k),
                     flags(stall, dmem_if.mem_req_valid, ld_valid, err), flags(0, 0, 0, 0));
            check_eq($sformatf("%s idle ld_data k=%0d", name, k), ld_data, exp_ld);
        end
    endtask

    logic [2:0] f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        logic [3:0] wm;
        int         w;
        rst_n                 = 1'b0;
        req_valid             = 1'b1;
        req_wmask             = 4'h0;
        req_addr              = 32'h0;
        req_wdata             = 32'h0;
        req_funct3            = 3'd0;
        dmem_if.mem_req_ready = 1'b0;
        dmem_if.mem_rsp_valid = 1'b0;
        dmem_if.mem_rsp_data  = 32'h0;
        #3;
        check_eq("reset flags", flags(stall, dmem_if.mem_req_valid, ld_valid, err), flags(0, 0, 0, 0));
        check_eq("reset ld_data", ld_data, 32'h0);
        check_eq("reset mem_addr", dmem_if.mem_addr, 32'h0);
        check_eq("reset mem_wmask", 32'(dmem_if.mem_wmask), 32'h0);
        check_eq("reset mem_wdata", dmem_if.mem_wdata, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        idle_cycles("post_reset", 2, 1'b0);

        run_txn("sw", 4'b1111, 32'h0000_0100, 32'hDEAD_BEEF, 3'd2, 0, 0, 32'h0);
        run_txn("lb", 4'b0000, 32'h0000_0103, 32'h0, 3'd0, 0, 3, 32'h80FF_1234);
        check_eq("lb value", ld_data, 32'hFFFF_FF80);
        run_txn("lbu", 4'b0000, 32'h0000_0103, 32'h0, 3'd4, 0, 3, 32'h80FF_1234);
        check_eq("lbu value", ld_data, 32'h0000_0080);
        run_txn("lh", 4'b0000, 32'h0000_0102, 32'h0, 3'd1, 0, 0, 32'h8001_7FFF);
        check_eq("lh value", ld_data, 32'hFFFF_8001);
        run_txn("lhu", 4'b0000, 32'h0000_0100, 32'h0, 3'd5, 1, 2, 32'h8001_7FFF);
        check_eq("lhu value", ld_data, 32'h0000_7FFF);
        run_txn("lw_mis", 4'b0000, 32'h0000_0101, 32'h0, 3'd2, 0, 0, 32'h1234_5678);
        check_eq("lw_mis value", ld_data, 32'h0);
        run_txn("sb_stall", 4'b0100, 32'h0000_0206, 32'h00AB_0000, 3'd0, 5, 0, 32'h0);
        run_txn("sw_b2b", 4'b0011, 32'h0000_0301, 32'h0000_5A5A, 3'd0, 0, 0, 32'h0);
        run_txn("tmo", 4'b0000, 32'h0000_0300, 32'h0, 3'd2, 0, int'(TO), 32'h0);
        idle_cycles("late_rsp", 2, 1'b1);

        // Reset asserted while a load sits in WAIT_RSP.
        @(negedge clk);
        req_valid  = 1'b1;
        req_wmask  = 4'b0000;
        req_addr   = 32'h0000_0200;
        req_funct3 = 3'd2;
        dmem_if.mem_req_ready = 1'b0;
        dmem_if.mem_rsp_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        dmem_if.mem_req_ready = 1'b1;
        @(negedge clk);
        dmem_if.mem_req_ready = 1'b0;
        #1;
        check_eq("rst_mid wait flags", flags(stall, dmem_if.mem_req_valid, ld_valid, err), flags(1, 0, 0, 0));
        @(negedge clk);
        req_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_ld = 32'h0;
        check_eq("rst_mid flags", flags(stall, dmem_if.mem_req_valid, ld_valid, err), flags(0, 0, 0, 0));
        check_eq("rst_mid ld_data", ld_data, 32'h0);
        check_eq("rst_mid mem_addr", dmem_if.mem_addr, 32'h0);
        check_eq("rst_mid mem_wmask", 32'(dmem_if.mem_wmask), 32'h0);
        check_eq("rst_mid mem_wdata", dmem_if.mem_wdata, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        idle_cycles("rst_late_rsp", 2, 1'b1);
        run_txn("sw_after_rst", 4'b1111, 32'h0000_0400, 32'hCAFE_F00D, 3'd2, 1, 0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            wm = ($urandom % 2 == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            w  = ($urandom % 8 == 0) ? int'(TO) : int'($urandom_range(0, 4));
            run_txn($sformatf("rnd%0d", i), wm, $urandom, $urandom, f3s[$urandom % 5],
                    int'($urandom_range(0, 3)), w, $urandom);
            if ($urandom % 3 == 0) idle_cycles($sformatf("rnd%0d", i), 1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory-stage responder for data-memory traffic: takes the byte-lane write mask (MemRW), address and store data produced by the execute-stage control, and performs the transaction against a handshaked data memory. It formats load data by offset, width and sign, and holds the pipeline stalled until the access completes. It sits between the M-stage pipeline registers and the DMEM port, and closes the loop opened by the execute-stage mask generation.

## Interface
- TIMEOUT, 64: max cycles in WAIT_RSP before aborting a load with error (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  M-stage instruction is a load or store this cycle
- req_wmask  in  4  byte-lane write mask from MemRW; 4'b0000 means load
- req_addr  in  32  full byte address (ALU output)
- req_wdata  in  32  store data, already lane-shifted
- req_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- stall  out  1  freeze IF/ID/X/M registers
- ld_valid  out  1  one-cycle pulse, ld_data is valid
- ld_data  out  32  aligned, extended load result
- err  out  1  one-cycle pulse: misaligned load or response timeout
- mem_req_valid  out  1  request to DMEM
- mem_req_ready  in  1  DMEM accepts request
- mem_addr  out  32  {req_addr[31:2],2'b00}
- mem_wmask  out  4  registered req_wmask
- mem_wdata  out  32  registered req_wdata
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  32  read word

## Operation
- States: IDLE, ISSUE, WAIT_RSP, DONE.
- IDLE: if req_valid, capture addr/wmask/wdata/funct3 into holding registers. A misaligned load (LH/LHU with addr[0]=1; LW with addr[1:0]≠0) goes to DONE with error flagged; otherwise go to ISSUE.
- ISSUE: mem_req_valid=1, with mem_addr/mem_wmask/mem_wdata driven from the holding registers. Hold them stable until mem_req_ready.
  - On handshake, a store goes to DONE and a load goes to WAIT_RSP.
- WAIT_RSP: on mem_rsp_valid, capture mem_rsp_data and go to DONE.
  - A cycle counter starts at 0 on entry. If the counter reaches TIMEOUT-1 with no response, go to DONE with error flagged.
- DONE: stall=0 and the pipeline advances at the clock edge ending this cycle.
  - Load without error: ld_valid=1.
  - Error: err=1, ld_valid=0, ld_data=0.
  - Next state is always IDLE.
- Load formatting uses byte offset o=addr[1:0]:
  - LB/LBU select byte o, sign- or zero-extend to 32 bits.
  - LH/LHU select halfword o[1], sign- or zero-extend.
  - LW passes the word through.
  - The result is registered; ld_data holds its value until the next DONE.
- Stores are not checked for alignment; MemRW already encodes lanes. Misaligned stores are issued as given.
- mem_rsp_valid outside WAIT_RSP is ignored. mem_req_ready outside ISSUE is ignored.
- req_* inputs are sampled only in IDLE; changes while stalled have no effect.

## Timing
- stall = (IDLE & req_valid) | ISSUE | WAIT_RSP. This is combinational from req_valid in IDLE and registered state otherwise.
- Store, ready immediately: C0 IDLE accept, C1 ISSUE handshake, C2 DONE. The instruction leaves M at the end of C2.
- Load, ready immediately, response one cycle later: C0 accept, C1 ISSUE, C2 WAIT_RSP with rsp_valid, C3 DONE with ld_valid. A response is never accepted in the handshake cycle.
- Misaligned load: C0 accept, C1 DONE with err. No memory request is made.
- Timeout: DONE occurs TIMEOUT cycles after entering WAIT_RSP.
- Back-to-back: req_valid in the IDLE cycle right after DONE is accepted. The minimum issue spacing is 3 cycles per store.
- Reset: state=IDLE, counter=0, and all registered outputs (ld_data, ld_valid, err, mem_req_valid, mem_addr, mem_wmask, mem_wdata) are 0.
  - stall=0 while rst_n=0.
  - Reset asserted mid-transaction drops mem_req_valid immediately and abandons the access; a later response is ignored.

## Test plan
- Store SW, wmask=1111, addr 0x100, wdata 0xDEADBEEF, ready held 1:
  - mem_req_valid for exactly 1 cycle with mem_addr=0x100, mem_wmask=1111.
  - stall high for 2 cycles, no ld_valid.
- LB at addr 0x103, rsp 0x80FF_1234 after 3 wait cycles: ld_data=0xFFFFFF80, ld_valid 1 cycle; the same with LBU gives 0x00000080.
- LH at 0x102 on word 0x8001_7FFF gives 0xFFFF8001; LHU at 0x100 gives 0x00007FFF; LW at 0x101 gives err pulse, no mem request, ld_data=0.
- mem_req_ready low for 5 cycles:
  - mem_addr, mem_wmask and mem_wdata stay constant and stall stays high.
  - Toggling req_* meanwhile does not alter the transaction.
- Load with no response, TIMEOUT=8: err asserted exactly 8 cycles after WAIT_RSP entry. A late rsp_valid is ignored and the state returns to IDLE.
- rst_n pulsed low while in WAIT_RSP: all outputs 0 asynchronously. After release, the following rsp_valid produces no ld_valid, and a new store completes normally.
